// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: request and response channels of the shared logic unit.
// master = requesters/consumer side, slave = arbiter side.
//   req_valid/req_ready  per-requester handshake, one-hot grant on req_ready
//   req_a/req_b/req_op   packed operands, slice i belongs to requester i
//   rsp_valid/rsp_ready  response handshake carrying rsp_id/rsp_data/rsp_zero
interface alu_share_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [N_REQ*2-1:0]     req_op;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [WIDTH-1:0]       rsp_data;
  logic                   rsp_zero;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_zero
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_zero
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin share of one logic unit among N_REQ requesters.
// Ports: clk, rst (sync, active high), bus (slave modport: request/response
// channels), alu_a/alu_b/alu_op to the shared unit, alu_out/alu_zero from it.
// Option: ALU_PIPE_EN -> shared unit output is registered, WAIT state added.
module alu_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  alu_share_arbiter_if.slave bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero
);
  localparam int ID_W = $clog2(N_REQ);
  localparam int SW   = ID_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t state, state_nxt;

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    rr_nxt;
  logic [ID_W-1:0]    lat_id;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_any;
  logic               xfer;
  logic               capture;
  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [SW-1:0]      sum;
  logic [SW-1:0]      inc;
  logic [ID_W-1:0]    rsp_id_q;
  logic [WIDTH-1:0]   rsp_data_q;
  logic               rsp_zero_q;

  // Rotate the valid vector so bit 0 is the requester at rr_ptr; the first
  // set bit of the rotated view is the winner.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    sum     = '0;
    dbl     = {bus.req_valid, bus.req_valid} >> rr_ptr;
    rot     = dbl[N_REQ-1:0];
    for (int k = 0; k < N_REQ; k++) begin
      if (!gnt_any && rot[k]) begin
        gnt_any = 1'b1;
        sum     = {1'b0, rr_ptr} + SW'(k);
        if (sum >= SW'(N_REQ)) sum = sum - SW'(N_REQ);
        gnt_id  = sum[ID_W-1:0];
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (state == IDLE && !rst && gnt_any)
      bus.req_ready[gnt_id] = 1'b1;
  end

  assign xfer = state == IDLE && !rst && gnt_any;

  always_comb begin
    inc    = {1'b0, gnt_id} + SW'(1);
    rr_nxt = inc[ID_W-1:0];
    if (inc == SW'(N_REQ)) rr_nxt = '0;
  end

`ifdef ALU_PIPE_EN
  assign capture = state == WAIT;
`else
  assign capture = state == ISSUE;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (xfer) state_nxt = ISSUE;
`ifdef ALU_PIPE_EN
      ISSUE: state_nxt = WAIT;
`else
      ISSUE: state_nxt = RESP;
`endif
      WAIT:  state_nxt = RESP;
      RESP:  if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latches double as the alu_* drivers, so they only move on a
  // grant and hold their value through RESP and IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      lat_id     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
      rsp_zero_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (xfer) begin
        rr_ptr <= rr_nxt;
        lat_id <= gnt_id;
        alu_a  <= bus.req_a[int'(gnt_id)*WIDTH +: WIDTH];
        alu_b  <= bus.req_b[int'(gnt_id)*WIDTH +: WIDTH];
        alu_op <= bus.req_op[int'(gnt_id)*2 +: 2];
      end
      if (capture) begin
        rsp_id_q   <= lat_id;
        rsp_data_q <= alu_out;
        rsp_zero_q <= alu_zero;
      end
    end
  end

  assign bus.rsp_valid = state == RESP;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_zero  = rsp_zero_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed bench for the shared logic-unit arbiter.
// Hosts a behavioural logic unit (registered under ALU_PIPE_EN).
module tb_alu_share_arbiter;
  localparam int N = 4;
  localparam int W = 32;
`ifdef ALU_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [1:0]   alu_op;
  logic [W-1:0] alu_out;
  logic         alu_zero;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_share_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

  alu_share_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .alu_out  (alu_out),
    .alu_zero (alu_zero)
  );

  function automatic logic [W-1:0] lu(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic [1:0]   op
  );
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

`ifdef ALU_PIPE_EN
  always_ff @(posedge clk) begin
    alu_out  <= lu(alu_a, alu_b, alu_op);
    alu_zero <= lu(alu_a, alu_b, alu_op) == '0;
  end
`else
  always_comb begin
    alu_out  = lu(alu_a, alu_b, alu_op);
    alu_zero = alu_out == '0;
  end
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(
    input int           id,
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic [1:0]   op
  );
    bus.req_a[id*W +: W] = a;
    bus.req_b[id*W +: W] = b;
    bus.req_op[id*2 +: 2] = op;
    bus.req_valid[id] = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    tick();
    tick();
    #1;
    vectors++;
    if (bus.req_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL rst_ready got %b exp 0000", bus.req_ready);
    end
    vectors++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_id !== 2'd0 ||
        bus.rsp_data !== 32'h0 || bus.rsp_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_rsp got v=%b id=%0d d=%h z=%b exp 0/0/0/0",
               bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_zero);
    end
    vectors++;
    if (alu_a !== 32'h0 || alu_b !== 32'h0 || alu_op !== 2'b00) begin
      miscompares++;
      $display("FAIL rst_alu got a=%h b=%h op=%b exp 0", alu_a, alu_b, alu_op);
    end
    bus.req_valid = '0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_and_zero();
    drive_req(0, 32'h2, 32'h8, 2'b00);
    #1;
    vectors++;
    if (bus.req_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL and_grant got %b exp 0001", bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    #1;
    vectors++;
    if (bus.req_ready !== 4'b0000 || bus.rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL and_issue got rdy=%b v=%b exp 0000/0",
               bus.req_ready, bus.rsp_valid);
    end
    vectors++;
    if (alu_a !== 32'h2 || alu_b !== 32'h8 || alu_op !== 2'b00) begin
      miscompares++;
      $display("FAIL and_alu got a=%h b=%h op=%b exp 2/8/00", alu_a, alu_b, alu_op);
    end
`ifdef ALU_PIPE_EN
    tick();
    vectors++;
    if (bus.rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL and_wait got v=%b exp 0", bus.rsp_valid);
    end
`endif
    tick();
    #1;
    vectors++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h0 ||
        bus.rsp_zero !== 1'b1 || bus.rsp_id !== 2'd0) begin
      miscompares++;
      $display("FAIL and_rsp got v=%b d=%h z=%b id=%0d exp 1/0/1/0",
               bus.rsp_valid, bus.rsp_data, bus.rsp_zero, bus.rsp_id);
    end
    tick();
    vectors++;
    if (bus.rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL and_done got v=%b exp 0", bus.rsp_valid);
    end
  endtask

  task automatic test_req2();
    drive_req(2, 32'h8, 32'h8, 2'b00);
    #1;
    vectors++;
    if (bus.req_ready !== 4'b0100) begin
      miscompares++;
      $display("FAIL req2_grant got %b exp 0100", bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    repeat (LAT - 1) tick();
    #1;
    vectors++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h8 ||
        bus.rsp_zero !== 1'b0 || bus.rsp_id !== 2'd2) begin
      miscompares++;
      $display("FAIL req2_rsp got v=%b d=%h z=%b id=%0d exp 1/8/0/2",
               bus.rsp_valid, bus.rsp_data, bus.rsp_zero, bus.rsp_id);
    end
    tick();
  endtask

  task automatic test_round_robin();
    int ngr;
    int nrsp;
    ngr = 0;
    nrsp = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++)
      drive_req(i, W'(i + 1), 32'h0, 2'b10);
    for (int c = 0; c < 5 * (LAT + 1); c++) begin
      #1;
      if (bus.req_ready !== 4'b0000) begin
        vectors++;
        if (bus.req_ready !== 4'(1 << (ngr % N)) || c != ngr * (LAT + 1)) begin
          miscompares++;
          $display("FAIL rr_grant got %b at cyc %0d exp %b at cyc %0d",
                   bus.req_ready, c, 4'(1 << (ngr % N)), ngr * (LAT + 1));
        end
        ngr++;
      end
      if (bus.rsp_valid === 1'b1) begin
        vectors++;
        if (bus.rsp_id !== 2'(nrsp % N) || bus.rsp_data !== W'(nrsp % N + 1)) begin
          miscompares++;
          $display("FAIL rr_rsp got id=%0d d=%h exp id=%0d d=%h",
                   bus.rsp_id, bus.rsp_data, nrsp % N, nrsp % N + 1);
        end
        nrsp++;
      end
      tick();
    end
    bus.req_valid = '0;
    vectors++;
    if (ngr != 5 || nrsp != 5) begin
      miscompares++;
      $display("FAIL rr_count got %0d grants %0d rsps exp 5/5", ngr, nrsp);
    end
  endtask

  task automatic test_backpressure();
    bus.rsp_ready = 1'b0;
    drive_req(1, 32'h5A, 32'h0F, 2'b01);
    #1;
    vectors++;
    if (bus.req_ready !== 4'b0010) begin
      miscompares++;
      $display("FAIL bp_grant got %b exp 0010", bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    drive_req(3, 32'h3, 32'h1, 2'b00);
    repeat (LAT - 1) tick();
    for (int c = 0; c < 5; c++) begin
      #1;
      vectors++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 ||
          bus.rsp_data !== 32'h5F || bus.rsp_zero !== 1'b0 ||
          bus.req_ready !== 4'b0000) begin
        miscompares++;
        $display("FAIL bp_hold cyc %0d got v=%b id=%0d d=%h z=%b rdy=%b exp 1/1/5f/0/0000",
                 c, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_zero,
                 bus.req_ready);
      end
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    vectors++;
    if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL bp_hs got v=%b rdy=%b exp 1/0000", bus.rsp_valid, bus.req_ready);
    end
    tick();
    vectors++;
    if (bus.req_ready !== 4'b1000 || bus.rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_next got rdy=%b v=%b exp 1000/0", bus.req_ready, bus.rsp_valid);
    end
    tick();
    bus.req_valid = '0;
    repeat (LAT - 1) tick();
    #1;
    vectors++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd3 ||
        bus.rsp_data !== 32'h1 || bus.rsp_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_rsp3 got v=%b id=%0d d=%h z=%b exp 1/3/1/0",
               bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_zero);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    drive_req(1, 32'h11, 32'h22, 2'b10);
    #1;
    vectors++;
    if (bus.req_ready !== 4'b0010) begin
      miscompares++;
      $display("FAIL mrst_grant got %b exp 0010", bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL mrst_issue got v=%b rdy=%b exp 0/0000", bus.rsp_valid, bus.req_ready);
    end
    tick();
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_id !== 2'd0 ||
        bus.rsp_data !== 32'h0 || bus.rsp_zero !== 1'b0 ||
        alu_a !== 32'h0 || alu_b !== 32'h0 || alu_op !== 2'b00) begin
      miscompares++;
      $display("FAIL mrst_out got v=%b id=%0d d=%h z=%b a=%h b=%h op=%b exp all 0",
               bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_zero,
               alu_a, alu_b, alu_op);
    end
    for (int c = 0; c < LAT + 1; c++) begin
      tick();
      vectors++;
      if (bus.rsp_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL mrst_norsp cyc %0d got v=%b exp 0", c, bus.rsp_valid);
      end
    end
    bus.req_valid = '1;
    #1;
    vectors++;
    if (bus.req_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL mrst_ptr got %b exp 0001", bus.req_ready);
    end
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_nor();
    drive_req(0, 32'hFFFF_FFFF, 32'h0, 2'b11);
    #1;
    vectors++;
    if (bus.req_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL nor_grant got %b exp 0001", bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    #1;
    vectors++;
    if (alu_a !== 32'hFFFF_FFFF || alu_b !== 32'h0 || alu_op !== 2'b11) begin
      miscompares++;
      $display("FAIL nor_alu got a=%h b=%h op=%b exp ffffffff/0/11",
               alu_a, alu_b, alu_op);
    end
`ifdef ALU_PIPE_EN
    tick();
    vectors++;
    if (bus.rsp_valid !== 1'b0 || alu_op !== 2'b11) begin
      miscompares++;
      $display("FAIL nor_wait got v=%b op=%b exp 0/11", bus.rsp_valid, alu_op);
    end
`endif
    tick();
    vectors++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h0 ||
        bus.rsp_zero !== 1'b1 || bus.rsp_id !== 2'd0) begin
      miscompares++;
      $display("FAIL nor_rsp got v=%b d=%h z=%b id=%0d exp 1/0/1/0",
               bus.rsp_valid, bus.rsp_data, bus.rsp_zero, bus.rsp_id);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_op = '0;
    bus.rsp_ready = 1'b1;
    test_reset();
    test_and_zero();
    test_req2();
    test_round_robin();
    test_backpressure();
    test_mid_reset();
    test_nor();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
